// File: rtl/data_mem_pkg.sv
// Shared definitions for the MEM-stage data memory: RV32 load/store width
// codes, FSM state encoding, wait-counter width and request-check helpers.
// Optional feature macro used by these files: DMEM_MISALIGN_TRAP_EN.
package data_mem_pkg;

    // RV32 funct3 width/sign codes for loads and stores
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Wide enough for a wait-state count of 0..7
    localparam int WAIT_CNT_W = 3;

    // FSM state encoding
    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t WAIT = 2'd1;
    localparam state_t RESP = 2'd2;

    // Unsigned variants only exist for loads; 011/110/111 are never legal
    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        case (f3)
            F3_B, F3_H, F3_W: f3_legal = 1'b1;
            F3_BU, F3_HU:     f3_legal = ~we;
            default:          f3_legal = 1'b0;
        endcase
    endfunction

    // Halfwords need addr[0]=0, words need addr[1:0]=0
    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] lo);
        case (f3)
            F3_H, F3_HU: f3_misaligned = lo[0];
            F3_W:        f3_misaligned = |lo;
            default:     f3_misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_if.sv
// Request/response bus of the data memory: valid/ready request channel
// and valid/ready response channel.
interface data_mem_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) ();
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [2:0]            req_funct3;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_mem_lane_fmt.sv
// Combinational lane formatter: store byte enables and replicated store
// data, plus load byte/half extraction with sign or zero extension.
// Low address bits that would misalign a half/word are ignored here
// (access aligned down); trapping them is decided by the top.
module data_mem_lane_fmt
    import data_mem_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wlane_o,
    output logic [31:0] rdata_o
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Select the addressed lane and build enables / merged data per width code
    always_comb begin
        byte_sel = rword_i[{addr_lo_i, 3'b000} +: 8];
        half_sel = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];
        be_o     = 4'b0000;
        wlane_o  = 32'h0;
        rdata_o  = 32'h0;
        case (funct3_i)
            F3_B: begin
                be_o    = 4'b0001 << addr_lo_i;
                wlane_o = {4{wdata_i[7:0]}};
                rdata_o = {{24{byte_sel[7]}}, byte_sel};
            end
            F3_H: begin
                be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wlane_o = {2{wdata_i[15:0]}};
                rdata_o = {{16{half_sel[15]}}, half_sel};
            end
            F3_W: begin
                be_o    = 4'b1111;
                wlane_o = wdata_i;
                rdata_o = rword_i;
            end
            F3_BU:   rdata_o = {24'h0, byte_sel};
            F3_HU:   rdata_o = {16'h0, half_sel};
            default: ;
        endcase
    end
endmodule

// File: rtl/data_mem_pipe.sv
// Handshaked data memory for the MEM stage. One request per handshake,
// byte-enabled stores, extended loads, WAIT_STATES extra cycles before the
// response. Define DMEM_MISALIGN_TRAP_EN to reject misaligned half/word
// accesses; otherwise they are silently aligned down.
module data_mem_pipe
    import data_mem_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int MEM_SIZE    = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    data_mem_if.slave  bus
);
    localparam int IDX_W = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
    localparam logic [WAIT_CNT_W-1:0] LAST_WAIT =
        WAIT_CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
    localparam state_t FIRST_STATE = (WAIT_STATES > 0) ? WAIT : RESP;

    logic [DATA_WIDTH-1:0] mem_q [MEM_SIZE];

    state_t                state_q, state_d;
    logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;

    logic [ADDR_WIDTH-3:0] word_idx;
    logic [IDX_W-1:0]      mem_idx;
    logic                  in_range;
    logic                  misaligned;
    logic                  req_err;
    logic                  accept;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [3:0]            be;
    logic [DATA_WIDTH-1:0] wlane;
    logic [DATA_WIDTH-1:0] load_data;

    assign word_idx = bus.req_addr[ADDR_WIDTH-1:2];
    assign mem_idx  = bus.req_addr[IDX_W+1:2];
    assign in_range = word_idx < (ADDR_WIDTH-2)'(MEM_SIZE);
    assign rd_word  = mem_q[mem_idx];

`ifdef DMEM_MISALIGN_TRAP_EN
    assign misaligned = f3_misaligned(bus.req_funct3, bus.req_addr[1:0]);
`else
    assign misaligned = 1'b0;
`endif

    assign req_err       = ~in_range | ~f3_legal(bus.req_we, bus.req_funct3) | misaligned;
    assign bus.req_ready = (state_q == IDLE) | ((state_q == RESP) & bus.rsp_ready);
    assign accept        = bus.req_valid & bus.req_ready;
    // A request presented during reset is dropped, so it must not write either
    assign wr_en         = accept & bus.req_we & ~req_err & rst_n;

    data_mem_lane_fmt u_lane_fmt (
        .funct3_i  (bus.req_funct3),
        .addr_lo_i (bus.req_addr[1:0]),
        .wdata_i   (bus.req_wdata),
        .rword_i   (rd_word),
        .be_o      (be),
        .wlane_o   (wlane),
        .rdata_o   (load_data)
    );

    // Byte-enabled store into the addressed word at the accepting edge
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_en && be[i]) begin
                mem_q[mem_idx][8*i +: 8] <= wlane[8*i +: 8];
            end
        end
    end

    // Next state: wait-state countdown and back-to-back hand-over in RESP
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            IDLE: if (accept) state_d = FIRST_STATE;
            WAIT: begin
                if (wait_cnt_q == LAST_WAIT) state_d = RESP;
                else                         wait_cnt_d = wait_cnt_q + 1'b1;
            end
            RESP: if (bus.rsp_ready) state_d = accept ? FIRST_STATE : IDLE;
            default: state_d = IDLE;
        endcase
        if (accept) wait_cnt_d = '0;
    end

    // Response payload captured at acceptance; stores and errors return zero
    always_comb begin
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        if (accept) begin
            rsp_rdata_d = (req_err || bus.req_we) ? '0 : load_data;
            rsp_err_d   = req_err;
        end
    end

    // Control and response registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wait_cnt_q  <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_pipe.sv
// Bench for data_mem_pipe: a zero-wait-state instance driven from a vector
// table with a response scoreboard, and a three-wait-state instance for
// latency/backpressure sequences. Honours DMEM_MISALIGN_TRAP_EN.
module tb_data_mem_pipe;
    import data_mem_pkg::*;

`ifdef DMEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t vt[$];
    exp_t exp_q[$];

    always #5 clk = ~clk;

    data_mem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m0 ();
    data_mem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m3 ();

    data_mem_pipe #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_SIZE(256), .WAIT_STATES(0)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (m0)
    );

    data_mem_pipe #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_SIZE(256), .WAIT_STATES(3)) u_dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (m3)
    );

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, want %b", name, act, exp);
        end else begin
            $display("ok   %s: %b", name, act);
        end
    endtask

    task automatic add(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] er, input logic ee);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wd; v.exp_rdata = er; v.exp_err = ee;
        vt.push_back(v);
    endtask

    // Present one request on the zero-wait instance; expectation is queued
    // as the request is accepted. Leaves req_valid high for back-to-back use.
    task automatic send(input vec_t v);
        int   guard;
        exp_t e;
        m0.req_valid  = 1'b1;
        m0.req_we     = v.we;
        m0.req_funct3 = v.f3;
        m0.req_addr   = v.addr;
        m0.req_wdata  = v.wdata;
        guard = 0;
        while (!m0.req_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 50) begin
            n_cmp++; n_bad++;
            $display("FAIL send_timeout: req_ready stuck at 0, want 1 (addr %h)", v.addr);
        end
        e.rdata = v.exp_rdata;
        e.err   = v.exp_err;
        exp_q.push_back(e);
        $display("req  we=%b f3=%b addr=%h wdata=%h", v.we, v.f3, v.addr, v.wdata);
        @(posedge clk); #1;
    endtask

    task automatic mkvec(output vec_t v, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] er);
        v.we = we; v.f3 = f3; v.addr = addr; v.wdata = 32'h0; v.exp_rdata = er; v.exp_err = 1'b0;
    endtask

    // Response scoreboard for the zero-wait instance
    always @(negedge clk) begin
        if (rst_n && m0.rsp_valid && m0.rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL stray_rsp: got response rdata=%h err=%b, want none", m0.rsp_rdata, m0.rsp_err);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                n_cmp++;
                if (m0.rsp_rdata !== e.rdata || m0.rsp_err !== e.err) begin
                    n_bad++;
                    $display("FAIL rsp: got rdata=%h err=%b, want rdata=%h err=%b",
                             m0.rsp_rdata, m0.rsp_err, e.rdata, e.err);
                end else begin
                    $display("rsp  rdata=%h err=%b", m0.rsp_rdata, m0.rsp_err);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int   guard;

        // Vector table: {we, funct3, addr, wdata, expected rdata, expected err}
        add(1, F3_W,  32'h10,  32'hDEADBEEF, 32'h0,        0);
        add(0, F3_W,  32'h10,  32'h0,        32'hDEADBEEF, 0);
        add(0, F3_B,  32'h13,  32'h0,        32'hFFFFFFDE, 0);
        add(0, F3_BU, 32'h13,  32'h0,        32'h000000DE, 0);
        add(0, F3_B,  32'h10,  32'h0,        32'hFFFFFFEF, 0);
        add(0, F3_H,  32'h12,  32'h0,        32'hFFFFDEAD, 0);
        add(0, F3_HU, 32'h10,  32'h0,        32'h0000BEEF, 0);
        add(1, F3_W,  32'h20,  32'h11223344, 32'h0,        0);
        add(1, F3_H,  32'h22,  32'h00008001, 32'h0,        0);
        add(0, F3_W,  32'h20,  32'h0,        32'h80013344, 0);
        add(0, F3_HU, 32'h22,  32'h0,        32'h00008001, 0);
        add(0, F3_H,  32'h22,  32'h0,        32'hFFFF8001, 0);
        add(1, F3_B,  32'h21,  32'h123456A5, 32'h0,        0);
        add(0, F3_W,  32'h20,  32'h0,        32'h8001A544, 0);
        add(0, F3_B,  32'h21,  32'h0,        32'hFFFFFFA5, 0);
        add(1, F3_W,  32'h00,  32'hCAFEF00D, 32'h0,        0);
        add(0, F3_W,  32'h400, 32'h0,        32'h0,        1);
        add(1, F3_W,  32'h400, 32'h12345678, 32'h0,        1);
        add(0, F3_W,  32'h00,  32'h0,        32'hCAFEF00D, 0);
        add(0, 3'b011, 32'h20, 32'h0,        32'h0,        1);
        add(0, 3'b110, 32'h20, 32'h0,        32'h0,        1);
        add(0, 3'b111, 32'h20, 32'h0,        32'h0,        1);
        add(1, F3_BU, 32'h20,  32'h00000000, 32'h0,        1);
        add(1, F3_HU, 32'h20,  32'h00000000, 32'h0,        1);
        add(1, 3'b011, 32'h20, 32'hFFFFFFFF, 32'h0,        1);
        add(0, F3_W,  32'h20,  32'h0,        32'h8001A544, 0);
        add(1, F3_W,  32'h04,  32'h55667788, 32'h0,        0);
        add(1, F3_W,  32'h06,  32'h99999999, 32'h0,        TRAP);
        add(0, F3_W,  32'h04,  32'h0,        TRAP ? 32'h55667788 : 32'h99999999, 0);
        add(0, F3_H,  32'h05,  32'h0,        TRAP ? 32'h0 : 32'hFFFF9999, TRAP);
        add(0, F3_B,  32'h07,  32'h0,        TRAP ? 32'h00000055 : 32'hFFFFFF99, 0);
        add(0, F3_W,  32'h13,  32'h0,        TRAP ? 32'h0 : 32'hDEADBEEF, TRAP);

        rst_n = 1'b0;
        m0.req_valid = 0; m0.req_we = 0; m0.req_funct3 = 0; m0.req_addr = 0; m0.req_wdata = 0;
        m0.rsp_ready = 0;
        m3.req_valid = 0; m3.req_we = 0; m3.req_funct3 = 0; m3.req_addr = 0; m3.req_wdata = 0;
        m3.rsp_ready = 0;
        repeat (3) @(posedge clk);
        #1;
        check1 ("reset_valid", m0.rsp_valid, 1'b0);
        check32("reset_rdata", m0.rsp_rdata, 32'h0);
        check1 ("reset_err",   m0.rsp_err,   1'b0);
        check1 ("reset_valid3", m3.rsp_valid, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check1 ("idle_ready",  m0.req_ready, 1'b1);

        // Three wait states: store first, then a load held under backpressure
        m3.rsp_ready = 1'b1;
        m3.req_valid = 1'b1; m3.req_we = 1'b1; m3.req_funct3 = F3_W;
        m3.req_addr = 32'h40; m3.req_wdata = 32'h0BADF00D;
        @(posedge clk); #1;
        m3.req_valid = 1'b0;
        guard = 0;
        while (!m3.rsp_valid && guard < 10) begin
            @(posedge clk); #1;
            guard++;
        end
        check1 ("w3_store_seen", m3.rsp_valid, 1'b1);
        check32("w3_store_rdata", m3.rsp_rdata, 32'h0);
        check1 ("w3_store_err",  m3.rsp_err, 1'b0);
        @(posedge clk); #1;
        m3.rsp_ready = 1'b0;
        m3.req_valid = 1'b1; m3.req_we = 1'b0; m3.req_funct3 = F3_W; m3.req_addr = 32'h40;
        @(posedge clk); #1;
        // Second request stays pending until the first response is taken
        m3.req_funct3 = F3_B; m3.req_addr = 32'h43;
        for (int i = 0; i < 3; i++) begin
            check1("w3_lat_valid", m3.rsp_valid, 1'b0);
            check1("w3_lat_ready", m3.req_ready, 1'b0);
            @(posedge clk); #1;
        end
        for (int i = 0; i < 5; i++) begin
            check1 ("w3_hold_valid", m3.rsp_valid, 1'b1);
            check32("w3_hold_rdata", m3.rsp_rdata, 32'h0BADF00D);
            check1 ("w3_hold_err",   m3.rsp_err,   1'b0);
            check1 ("w3_hold_ready", m3.req_ready, 1'b0);
            @(posedge clk); #1;
        end
        m3.rsp_ready = 1'b1;
        #1;
        check1("w3_b2b_ready", m3.req_ready, 1'b1);
        @(posedge clk); #1;
        m3.req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check1("w3_b2b_wait", m3.rsp_valid, 1'b0);
            @(posedge clk); #1;
        end
        check1 ("w3_lb_valid", m3.rsp_valid, 1'b1);
        check32("w3_lb_rdata", m3.rsp_rdata, 32'h0000000B);
        @(posedge clk); #1;
        check1 ("w3_drained",  m3.rsp_valid, 1'b0);

        // Table, back-to-back on the zero-wait instance
        m0.rsp_ready = 1'b1;
        for (int i = 0; i < vt.size(); i++) send(vt[i]);
        m0.req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Four loads in consecutive cycles, one response per cycle
        for (int i = 0; i < 4; i++) begin
            case (i)
                0:       mkvec(v, 0, F3_W,  32'h10, 32'hDEADBEEF);
                1:       mkvec(v, 0, F3_W,  32'h20, 32'h8001A544);
                2:       mkvec(v, 0, F3_W,  32'h00, 32'hCAFEF00D);
                default: mkvec(v, 0, F3_BU, 32'h13, 32'h000000DE);
            endcase
            send(v);
            check1("b2b_valid", m0.rsp_valid, 1'b1);
        end
        m0.req_valid = 1'b0;
        @(posedge clk); #1;
        check1("b2b_end_valid", m0.rsp_valid, 1'b0);

        // Reset while a response is pending drops it; memory survives
        m0.rsp_ready = 1'b0;
        mkvec(v, 0, F3_W, 32'h20, 32'h8001A544);
        send(v);
        m0.req_valid = 1'b0;
        check1("pre_rst_valid", m0.rsp_valid, 1'b1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        exp_q.delete();
        check1 ("rst_drop_valid", m0.rsp_valid, 1'b0);
        check32("rst_drop_rdata", m0.rsp_rdata, 32'h0);
        rst_n = 1'b1;
        m0.rsp_ready = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check1("post_rst_valid", m0.rsp_valid, 1'b0);
        end
        mkvec(v, 0, F3_W, 32'h10, 32'hDEADBEEF);
        send(v);
        m0.req_valid = 1'b0;

        guard = 0;
        while (exp_q.size() != 0 && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL drain: %0d responses outstanding, want 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
